// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_pkg : shared state encoding, opcodes and sizing for mult_div_unit
// Revision 1.0
// ============================================================================
package mult_div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MULT   = 3'd1,
    DIV    = 3'd2,
    FINISH = 3'd3,
    DZ     = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // The iteration counter is loaded with WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W         = cnt_width(WIDTH_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/md_step.sv
`default_nettype none
// ============================================================================
// md_step : one combinational iteration of Booth multiply or restoring divide
// Revision 1.0
// ============================================================================
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             acc_q,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             nxt_q
);
  import mult_div_pkg::*;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // Booth add/sub is one bit wider so the shifted-in sign stays correct
    // even when the multiplicand is the most negative value.
    w_sum = {acc_hi[WIDTH-1], acc_hi};
    case ({acc_lo[0], acc_q})
      2'b01:   w_sum = {acc_hi[WIDTH-1], acc_hi} + {operand[WIDTH-1], operand};
      2'b10:   w_sum = {acc_hi[WIDTH-1], acc_hi} - {operand[WIDTH-1], operand};
      default: w_sum = {acc_hi[WIDTH-1], acc_hi};
    endcase

    w_rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, operand};

    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    nxt_q  = acc_q;
    if (op == OP_DIV) begin
      nxt_hi = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      nxt_q  = 1'b0;
    end else begin
      nxt_hi = w_sum[WIDTH:1];
      nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
      nxt_q  = acc_lo[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : multicycle signed multiply/divide sequencer producing HI/LO
// Revision 1.0
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mult_div_pkg::*;

  localparam int c_cnt_w = cnt_width(WIDTH);

  state_t             r_state;
  logic               r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_q;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [c_cnt_w-1:0] r_cnt;

  logic [WIDTH-1:0]   w_nxt_hi;
  logic [WIDTH-1:0]   w_nxt_lo;
  logic               w_nxt_q;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  assign w_abs_a = a[WIDTH-1] ? -a : a;
  assign w_abs_b = b[WIDTH-1] ? -b : b;

  md_step #(.WIDTH(WIDTH)) u_step (
    .op      (r_op),
    .acc_hi  (r_hi),
    .acc_lo  (r_lo),
    .acc_q   (r_q),
    .operand (r_opnd),
    .nxt_hi  (w_nxt_hi),
    .nxt_lo  (w_nxt_lo),
    .nxt_q   (w_nxt_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_op     <= OP_MULT;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_q      <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            r_op <= op;
            if (op == OP_MULT) begin
              r_hi    <= '0;
              r_lo    <= b;
              r_q     <= 1'b0;
              r_opnd  <= a;
              r_cnt   <= c_cnt_w'(ITERS);
              r_state <= MULT;
            end else if (b == '0) begin
              r_state <= DZ;
            end else begin
              // Divide runs on magnitudes; signs are re-applied in FINISH.
              r_hi    <= '0;
              r_lo    <= w_abs_a;
              r_q     <= 1'b0;
              r_opnd  <= w_abs_b;
              r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              r_neg_r <= a[WIDTH-1];
              r_cnt   <= c_cnt_w'(ITERS);
              r_state <= DIV;
            end
          end
        end
        MULT, DIV: begin
          r_hi  <= w_nxt_hi;
          r_lo  <= w_nxt_lo;
          r_q   <= w_nxt_q;
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          if (r_op == OP_MULT) begin
            hi <= r_hi;
            lo <= r_lo;
          end else begin
            hi <= r_neg_r ? -r_hi : r_hi;
            lo <= r_neg_q ? -r_lo : r_lo;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        DZ: begin
          div_zero <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : cycle-level reference model plus directed literal vectors
// Revision 1.0
// ============================================================================
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mult_div_unit #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed result straight from arithmetic; hi = product top / remainder.
  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint p;
    longint q;
    longint r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      p   = sx * sy;
      res = p;
    end else begin
      q   = sx / sy;
      r   = sx % sy;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Reference timeline: an accepted op keeps busy for ITERS+1 cycles then
  // pulses done with the new result; divide-by-zero is one busy cycle.
  int          m_left = 0;
  bit          m_dz = 1'b0;
  logic [63:0] m_res = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_dz = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left   <= 0;
      m_dz     <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_dz   <= 1'b0;
      exp_hi   <= '0;
      exp_lo   <= '0;
    end else begin
      exp_done <= 1'b0;
      exp_dz   <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          exp_busy <= 1'b1;
          if (op == 1'b1 && b == '0) begin
            m_left <= 1;
            m_dz   <= 1'b1;
          end else begin
            m_left <= ITERS + 1;
            m_dz   <= 1'b0;
            m_res  <= ref_result(op, a, b);
          end
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          exp_busy <= 1'b0;
          if (m_dz) begin
            exp_dz <= 1'b1;
          end else begin
            exp_done <= 1'b1;
            exp_hi   <= m_res[63:32];
            exp_lo   <= m_res[31:0];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc busy", busy, exp_busy);
      check("cyc done", done, exp_done);
      check("cyc div_zero", div_zero, exp_dz);
      check("cyc hi", hi, exp_hi);
      check("cyc lo", lo, exp_lo);
      if (done && div_zero) check("done_and_dz", 1, 0);
    end
  end

  task automatic run_op(input logic o, input logic [31:0] va, input logic [31:0] vb,
                        output int nbusy, output int ndone, output int ndz);
    bit fin;
    fin   = 1'b0;
    nbusy = 0;
    ndone = 0;
    ndz   = 0;
    @(negedge clk); #1;
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone++;
      if (div_zero) ndz++;
      if (!busy) fin = 1'b1;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still %b after 60 cycles, required 0", busy);
    end
  endtask

  task automatic expect_op(input string name, input logic o, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input int ebusy, input int edone, input int edz);
    int nb;
    int nd;
    int nz;
    run_op(o, va, vb, nb, nd, nz);
    check({name, " busy_cycles"}, 64'(nb), 64'(ebusy));
    check({name, " done_count"}, 64'(nd), 64'(edone));
    check({name, " dz_count"}, 64'(nz), 64'(edz));
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_zero", div_zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    cmp_en = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b1;

    expect_op("mul 7*-3",    1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1, 0);
    expect_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 1, 0);
    expect_op("mul -5*-6",   1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 33, 1, 0);
    expect_op("div -7/2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1, 0);
    expect_op("div 7/-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1, 0);
    expect_op("div 100/7",   1'b1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33, 1, 0);
    expect_op("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 33, 1, 0);
    expect_op("mul 0x12*1",  1'b0, 32'h12,        32'd1,         32'h0000_0000, 32'h0000_0012, 33, 1, 0);
    expect_op("div 5/0",     1'b1, 32'd5,         32'd0,         32'h0000_0000, 32'h0000_0012, 1,  0, 1);
    expect_op("div min/-1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1, 0);

    // Abort: start 3*4, re-pulse start while busy, then reset mid-flight.
    @(negedge clk); #1;
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1; start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort busy before reset", busy, 1);
    repeat (4) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort no late done", done, 0);
    check("abort still idle", busy, 0);

    expect_op("mul 3*4 after reset", 1'b0, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 33, 1, 0);

    // Pin the reference model itself against hand-computed values.
    check("model mul", ref_result(1'b0, 32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    check("model div", ref_result(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model ovf", ref_result(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
